// File: rtl/mcy_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcy_chk_pkg
// Brief    : Shared types for the MCY data-bus transaction checker.
// Revision : 1.0 - initial release
// ============================================================================
package mcy_chk_pkg;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISMATCH = 2'b01,
      FC_OVERFLOW = 2'b10,
      FC_TIMEOUT  = 2'b11
   } fail_code_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcy_txn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mcy_txn_fifo
// Brief    : Power-of-two transaction FIFO with flush; head is always visible.
// Revision : 1.0 - initial release
// ============================================================================
module mcy_txn_fifo
   import mcy_chk_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_push,
   input  logic i_pop,
   input  logic i_flush,
   input  txn_t i_data,
   output txn_t o_data,
   output logic o_empty,
   output logic o_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   txn_t        r_mem [DEPTH];
   logic        w_wr_en;
   logic        w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_rd_en = i_pop & ~o_empty;
   // A push into a full FIFO is dropped unless the head leaves in the same cycle.
   assign w_wr_en = i_push & (~o_full | w_rd_en);
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr_en && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/mcy_data_txn_checker.sv
`default_nettype none
// ============================================================================
// Module   : mcy_data_txn_checker
// Brief    : In-order compare of golden vs mutant data-bus transactions.
// Revision : 1.0 - initial release
// ============================================================================
module mcy_data_txn_checker
   import mcy_chk_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        gold_req_i,
   input  logic        gold_gnt_i,
   input  logic        gold_we_i,
   input  logic [3:0]  gold_be_i,
   input  logic [31:0] gold_addr_i,
   input  logic [31:0] gold_wdata_i,
   input  logic        mut_req_i,
   input  logic        mut_gnt_i,
   input  logic        mut_we_i,
   input  logic [3:0]  mut_be_i,
   input  logic [31:0] mut_addr_i,
   input  logic [31:0] mut_wdata_i,
   output logic        fail_o,
   output logic [1:0]  fail_code_o,
   output logic [31:0] fail_cycle_o,
   output logic [31:0] txn_count_o
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [31:0]   r_cyc;
   logic [31:0]   r_txn;
   logic [TW-1:0] r_to;
   logic [TW-1:0] w_to_inc;
   logic          r_fail;
   fail_code_e    r_fail_code;
   logic [31:0]   r_fail_cycle;

   logic       w_run;
   logic       w_flush;
   logic       w_g_push, w_m_push, w_pop;
   logic       w_g_empty, w_g_full, w_m_empty, w_m_full;
   txn_t       w_g_in, w_m_in, w_g_head, w_m_head;
   logic       w_mismatch, w_overflow, w_timeout, w_one_side, w_fail_evt;
   fail_code_e w_fail_code;

   assign w_g_in   = '{we: gold_we_i, be: gold_be_i, addr: gold_addr_i, wdata: gold_wdata_i};
   assign w_m_in   = '{we: mut_we_i, be: mut_be_i, addr: mut_addr_i, wdata: mut_wdata_i};
   assign w_g_push = w_run & gold_req_i & gold_gnt_i;
   assign w_m_push = w_run & mut_req_i & mut_gnt_i;

   // Pop decision uses start-of-cycle occupancy, so a same-cycle capture never reaches the comparator.
   assign w_pop      = w_run & ~w_g_empty & ~w_m_empty;
   assign w_mismatch = w_pop & (w_g_head != w_m_head);
   assign w_overflow = (w_g_push & w_g_full & ~w_pop) | (w_m_push & w_m_full & ~w_pop);
   assign w_one_side = w_run & (w_g_empty ^ w_m_empty);
   assign w_to_inc   = r_to + {{(TW-1){1'b0}}, 1'b1};
   assign w_timeout  = w_one_side & (w_to_inc == TW'(TIMEOUT_CYCLES));
   assign w_fail_evt = w_mismatch | w_overflow | w_timeout;

   mcy_txn_fifo #(.DEPTH(DEPTH)) u_gold_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_g_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_g_in),
      .o_data  (w_g_head),
      .o_empty (w_g_empty),
      .o_full  (w_g_full)
   );

   mcy_txn_fifo #(.DEPTH(DEPTH)) u_mut_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_m_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_m_in),
      .o_data  (w_m_head),
      .o_empty (w_m_empty),
      .o_full  (w_m_full)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (enable_i) w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (w_fail_evt)     w_state_nxt = ST_FAIL;
            else if (!enable_i) w_state_nxt = ST_IDLE;
         end
         ST_FAIL: w_state_nxt = ST_FAIL;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_run       = (r_state == ST_RUN);
      w_flush     = w_run & ~enable_i & ~w_fail_evt;
      w_fail_code = FC_NONE;
      if (w_mismatch)      w_fail_code = FC_MISMATCH;
      else if (w_overflow) w_fail_code = FC_OVERFLOW;
      else if (w_timeout)  w_fail_code = FC_TIMEOUT;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cyc        <= '0;
         r_txn        <= '0;
         r_to         <= '0;
         r_fail       <= 1'b0;
         r_fail_code  <= FC_NONE;
         r_fail_cycle <= '0;
      end else if (w_run) begin
         r_cyc <= sat_inc32(r_cyc);
         if (w_pop && !w_mismatch) r_txn <= sat_inc32(r_txn);
         r_to <= (w_one_side && !w_flush) ? w_to_inc : '0;
         if (w_fail_evt) begin
            r_fail       <= 1'b1;
            r_fail_code  <= w_fail_code;
            r_fail_cycle <= r_cyc;
         end
      end
   end

   assign fail_o       = r_fail;
   assign fail_code_o  = r_fail_code;
   assign fail_cycle_o = r_fail_cycle;
   assign txn_count_o  = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_mcy_data_txn_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcy_data_txn_checker
// Brief    : Directed scoreboard bench for the MCY transaction checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcy_data_txn_checker;
   import mcy_chk_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        g_req, g_gnt, m_req, m_gnt;
   txn_t        g_txn, m_txn;
   logic        fail_o;
   logic [1:0]  fail_code_o;
   logic [31:0] fail_cycle_o;
   logic [31:0] txn_count_o;

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_cyc    = 0;
   bit   m_run    = 1'b0;
   logic [31:0] m_prev = '0;
   txn_t q_gold[$];
   txn_t q_mut[$];

   always #5 clk = ~clk;

   mcy_data_txn_checker #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (en),
      .gold_req_i   (g_req),
      .gold_gnt_i   (g_gnt),
      .gold_we_i    (g_txn.we),
      .gold_be_i    (g_txn.be),
      .gold_addr_i  (g_txn.addr),
      .gold_wdata_i (g_txn.wdata),
      .mut_req_i    (m_req),
      .mut_gnt_i    (m_gnt),
      .mut_we_i     (m_txn.we),
      .mut_be_i     (m_txn.be),
      .mut_addr_i   (m_txn.addr),
      .mut_wdata_i  (m_txn.wdata),
      .fail_o       (fail_o),
      .fail_code_o  (fail_code_o),
      .fail_cycle_o (fail_cycle_o),
      .txn_count_o  (txn_count_o)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic txn_t mk(input int i);
      txn_t t;
      t.we    = i[0];
      t.be    = 4'(i) | 4'h1;
      t.addr  = 32'h1000 + 32'(i) * 32'd4;
      t.wdata = (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
      return t;
   endfunction

   // m_cyc mirrors the run-cycle count during the cycle currently being driven.
   task automatic tick();
      @(posedge clk);
      if (m_run) m_cyc++;
      m_run = en;
      #1;
   endtask

   task automatic drive(input logic gv, input txn_t gt, input logic mv, input txn_t mt);
      g_req = gv; g_gnt = gv; g_txn = gt;
      m_req = mv; m_gnt = mv; m_txn = mt;
      if (m_run && gv) q_gold.push_back(gt);
      if (m_run && mv) q_mut.push_back(mt);
      tick();
      g_req = 1'b0; g_gnt = 1'b0; m_req = 1'b0; m_gnt = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0;
      g_req = 1'b0; g_gnt = 1'b0; m_req = 1'b0; m_gnt = 1'b0;
      g_txn = '0; m_txn = '0;
      tick();
      q_gold.delete(); q_mut.delete();
      m_prev = '0; m_cyc = 0; m_run = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_fail"},  96'(fail_o), 96'd0);
      chk({tag, "_code"},  96'(fail_code_o), 96'd0);
      chk({tag, "_cycle"}, 96'(fail_cycle_o), 96'd0);
      chk({tag, "_txn"},   96'(txn_count_o), 96'd0);
   endtask

   // Scoreboard: every matched-pair increment retires the oldest expected pair.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && txn_count_o !== m_prev) begin
         txn_t gh, mh;
         chk("sb_count_step", 96'(txn_count_o), 96'(m_prev + 32'd1));
         chk("sb_queues_ready", 96'(q_gold.size() > 0 && q_mut.size() > 0), 96'd1);
         if (q_gold.size() > 0 && q_mut.size() > 0) begin
            gh = q_gold.pop_front();
            mh = q_mut.pop_front();
            chk("sb_pair_equal", 96'(mh), 96'(gh));
         end
         m_prev = txn_count_o;
      end
   end

   initial begin
      txn_t st, bad;
      int   c4;
      st = '{we: 1'b1, be: 4'hF, addr: 32'h1000, wdata: 32'hDEAD_BEEF};

      // Reset state
      do_reset();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // 1: identical streams, no skew, plus a request without grant
      en = 1'b1; tick();
      for (int i = 0; i < 100; i++) drive(1'b1, mk(i), 1'b1, mk(i));
      g_req = 1'b1; m_req = 1'b1; g_txn = mk(7); m_txn = mk(8); tick();
      g_req = 1'b0; m_req = 1'b0;
      idle(3);
      chk("t1_fail", 96'(fail_o), 96'd0);
      chk("t1_txn", 96'(txn_count_o), 96'd100);

      // 2: mutant lags by three stores
      do_reset(); rst_n = 1'b1;
      en = 1'b1; tick();
      for (int i = 0; i < 23; i++) drive(i < 20, st, i >= 3, st);
      idle(4);
      chk("t2_fail", 96'(fail_o), 96'd0);
      chk("t2_txn", 96'(txn_count_o), 96'd20);
      en = 1'b0; idle(2);
      for (int i = 0; i < 20; i++) drive(1'b1, mk(i), 1'b0, '0);
      chk("t2_idle_fail", 96'(fail_o), 96'd0);
      chk("t2_idle_txn_hold", 96'(txn_count_o), 96'd20);

      // 3: fifth mutant store carries corrupted data
      do_reset(); rst_n = 1'b1;
      en = 1'b1; tick();
      c4 = 0;
      for (int i = 0; i < 6; i++) begin
         bad = mk(i);
         if (i == 4) begin
            c4 = m_cyc;
            bad = st; bad.wdata = 32'hDEAD_BEEE;
            drive(1'b1, st, 1'b1, bad);
            chk("t3_no_early_fail", 96'(fail_o), 96'd0);
         end else begin
            drive(1'b1, mk(i), 1'b1, bad);
         end
         if (i == 5) begin
            chk("t3_fail", 96'(fail_o), 96'd1);
            chk("t3_code", 96'(fail_code_o), 96'(FC_MISMATCH));
            chk("t3_txn", 96'(txn_count_o), 96'd4);
            chk("t3_cycle", 96'(fail_cycle_o), 96'(c4 + 1));
         end
      end
      en = 1'b0; idle(3);
      en = 1'b1; idle(2);
      chk("t3_sticky_fail", 96'(fail_o), 96'd1);
      chk("t3_sticky_code", 96'(fail_code_o), 96'(FC_MISMATCH));
      chk("t3_sticky_cycle", 96'(fail_cycle_o), 96'(c4 + 1));

      // 4: golden overruns an empty mutant side
      do_reset(); rst_n = 1'b1;
      en = 1'b1; tick();
      for (int i = 0; i < 4; i++) drive(1'b1, mk(i), 1'b0, '0);
      chk("t4_full_no_fail", 96'(fail_o), 96'd0);
      drive(1'b1, mk(4), 1'b0, '0);
      chk("t4_fail", 96'(fail_o), 96'd1);
      chk("t4_code", 96'(fail_code_o), 96'(FC_OVERFLOW));
      chk("t4_cycle", 96'(fail_cycle_o), 96'd4);
      chk("t4_txn", 96'(txn_count_o), 96'd0);

      // 5: one golden transaction, mutant silent
      do_reset(); rst_n = 1'b1;
      en = 1'b1; tick();
      drive(1'b1, mk(1), 1'b0, '0);
      idle(15);
      chk("t5_before_timeout", 96'(fail_o), 96'd0);
      tick();
      chk("t5_fail", 96'(fail_o), 96'd1);
      chk("t5_code", 96'(fail_code_o), 96'(FC_TIMEOUT));
      chk("t5_cycle", 96'(fail_cycle_o), 96'd16);

      // 6: mismatch in a cycle that also pushes into the full golden FIFO
      do_reset(); rst_n = 1'b1;
      en = 1'b1; tick();
      for (int i = 0; i < 4; i++) drive(1'b1, mk(i), 1'b0, '0);
      drive(1'b0, '0, 1'b1, mk(99));
      drive(1'b1, mk(4), 1'b1, mk(5));
      chk("t6_fail", 96'(fail_o), 96'd1);
      chk("t6_code", 96'(fail_code_o), 96'(FC_MISMATCH));
      chk("t6_cycle", 96'(fail_cycle_o), 96'd5);
      do_reset();
      check_all_zero("t6_reset");
      rst_n = 1'b1;

      // 7: overflow and timeout in the same cycle
      en = 1'b1; tick();
      for (int i = 0; i < 4; i++) drive(1'b1, mk(i), 1'b0, '0);
      idle(12);
      chk("t7_before", 96'(fail_o), 96'd0);
      drive(1'b1, mk(4), 1'b0, '0);
      chk("t7_fail", 96'(fail_o), 96'd1);
      chk("t7_code", 96'(fail_code_o), 96'(FC_OVERFLOW));
      chk("t7_cycle", 96'(fail_cycle_o), 96'd16);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
